// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the instruction-fetch and data ports with alternating grants.
// Optional macro ARB_TIMEOUT_EN aborts a memory access after TIMEOUT BUSY cycles without m_ack.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ack,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ack,
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_be,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_ack,
  output logic                busy,
  output logic                err
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t              state, state_d;
  logic                ptr_data, ptr_data_d;   // 1: data wins the next contended grant
  logic                gnt_data, gnt_data_d;   // side owning the access in flight
  logic                pick_data;
  logic                tmo_hit;
  logic                m_req_d, m_we_d, if_ack_d, d_ack_d, busy_d, err_d;
  logic [ADDR_W-1:0]   m_addr_d;
  logic [DATA_W-1:0]   m_wdata_d, if_rdata_d, d_rdata_d;
  logic [DATA_W/8-1:0] m_be_d;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] tmo_cnt;

  // Held at zero outside BUSY, so every access starts counting from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              tmo_cnt <= '0;
    else if (state != BUSY) tmo_cnt <= '0;
    else if (!m_ack)        tmo_cnt <= tmo_cnt + CNT_W'(1);
  end

  assign tmo_hit = (state == BUSY) && !m_ack && (tmo_cnt == CNT_W'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign tmo_hit        = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d    = state;
    ptr_data_d = ptr_data;
    gnt_data_d = gnt_data;
    pick_data  = 1'b0;
    m_req_d    = m_req;
    m_we_d     = m_we;
    m_addr_d   = m_addr;
    m_wdata_d  = m_wdata;
    m_be_d     = m_be;
    if_rdata_d = if_rdata;
    d_rdata_d  = d_rdata;
    if_ack_d   = 1'b0;
    d_ack_d    = 1'b0;
    err_d      = 1'b0;
    busy_d     = busy;
    unique case (state)
      IDLE: begin
        if (if_req || d_req) begin
          pick_data  = d_req && (!if_req || ptr_data);
          gnt_data_d = pick_data;
          ptr_data_d = !pick_data;
          m_req_d    = 1'b1;
          busy_d     = 1'b1;
          state_d    = BUSY;
          if (pick_data) begin
            m_we_d    = d_we;
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
            m_be_d    = d_be;
          end else begin
            m_we_d    = 1'b0;
            m_addr_d  = if_addr;
            m_wdata_d = '0;
            m_be_d    = '1;
          end
        end
      end
      BUSY: begin
        if (m_ack || tmo_hit) begin
          // A timed-out access completes like a normal one but returns zero and flags err.
          m_req_d = 1'b0;
          err_d   = !m_ack;
          state_d = DONE;
          if (gnt_data) begin
            d_rdata_d = m_ack ? m_rdata : '0;
            d_ack_d   = 1'b1;
          end else begin
            if_rdata_d = m_ack ? m_rdata : '0;
            if_ack_d   = 1'b1;
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ptr_data <= 1'b1;
      gnt_data <= 1'b0;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_be     <= '0;
      if_rdata <= '0;
      d_rdata  <= '0;
      if_ack   <= 1'b0;
      d_ack    <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state    <= state_d;
      ptr_data <= ptr_data_d;
      gnt_data <= gnt_data_d;
      m_req    <= m_req_d;
      m_we     <= m_we_d;
      m_addr   <= m_addr_d;
      m_wdata  <= m_wdata_d;
      m_be     <= m_be_d;
      if_rdata <= if_rdata_d;
      d_rdata  <= d_rdata_d;
      if_ack   <= if_ack_d;
      d_ack    <= d_ack_d;
      busy     <= busy_d;
      err      <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run
// scored against a transaction-level model of grants, memory contents and acks.
module tb_mem_port_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BW  = DW / 8;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, m_ack = 1'b0;
  logic [AW-1:0] if_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0, m_rdata = '0;
  logic [BW-1:0] d_be = '0;
  logic [DW-1:0] if_rdata, d_rdata, m_wdata;
  logic [AW-1:0] m_addr;
  logic [BW-1:0] m_be;
  logic          if_ack, d_ack, m_req, m_we, busy, err;

  int checks = 0;
  int passed = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_rdata(m_rdata), .m_ack(m_ack), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [137:0] all_out;
    reset = 1'b1;
    #2;
    all_out = {if_ack, d_ack, m_req, m_we, busy, err, m_be, m_addr, m_wdata, if_rdata, d_rdata};
    checks++; if (all_out !== '0) $display("FAIL reset_async: got %h want 0", all_out); else passed++;
    tick(); tick();
    all_out = {if_ack, d_ack, m_req, m_we, busy, err, m_be, m_addr, m_wdata, if_rdata, d_rdata};
    checks++; if (all_out !== '0) $display("FAIL reset_held: got %h want 0", all_out); else passed++;
    reset = 1'b0;
    tick();
    checks++; if ({m_req, busy} !== 2'b00) $display("FAIL reset_release_idle: got %b want 00", {m_req, busy}); else passed++;
  endtask

  task automatic test_contention();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'h12345678; d_be = 4'b0011;
    if_req = 1'b1; if_addr = 32'h104;
    tick();
    checks++;
    if ({m_req, m_we, m_addr, m_be, m_wdata} !== {1'b1, 1'b1, 32'h2000, 4'b0011, 32'h12345678})
      $display("FAIL contend_store_first: got req=%b we=%b addr=%h be=%b wdata=%h want 1 1 2000 0011 12345678",
               m_req, m_we, m_addr, m_be, m_wdata);
    else passed++;
    m_ack = 1'b1; m_rdata = 32'h0BAD0001;
    tick();
    checks++;
    if ({if_ack, d_ack, d_rdata} !== {2'b01, 32'h0BAD0001})
      $display("FAIL contend_store_ack: got if_ack=%b d_ack=%b d_rdata=%h want 0 1 0bad0001", if_ack, d_ack, d_rdata);
    else passed++;
    // Data re-raises a new load on the edge ending DONE, so both contend again.
    d_we = 1'b0; d_addr = 32'h2004; d_be = 4'hF; m_ack = 1'b0;
    tick();
    checks++; if ({m_req, busy} !== 2'b00) $display("FAIL contend_idle_gap: got %b want 00", {m_req, busy}); else passed++;
    tick();
    checks++;
    if ({m_req, m_we, m_addr, m_be} !== {1'b1, 1'b0, 32'h104, 4'hF})
      $display("FAIL contend_fetch_second: got req=%b we=%b addr=%h be=%h want 1 0 104 f", m_req, m_we, m_addr, m_be);
    else passed++;
    m_ack = 1'b1; m_rdata = 32'h00000013;
    tick();
    checks++;
    if ({if_ack, d_ack, if_rdata} !== {2'b10, 32'h00000013})
      $display("FAIL contend_fetch_ack: got if_ack=%b d_ack=%b if_rdata=%h want 1 0 00000013", if_ack, d_ack, if_rdata);
    else passed++;
    if_req = 1'b0; m_ack = 1'b0;
    tick(); tick();
    checks++;
    if ({m_req, m_we, m_addr} !== {1'b1, 1'b0, 32'h2004})
      $display("FAIL contend_load_third: got req=%b we=%b addr=%h want 1 0 2004", m_req, m_we, m_addr);
    else passed++;
    m_ack = 1'b1; m_rdata = 32'h11223344;
    tick();
    checks++;
    if ({d_ack, d_rdata, if_rdata} !== {1'b1, 32'h11223344, 32'h00000013})
      $display("FAIL contend_load_ack: got d_ack=%b d_rdata=%h if_rdata=%h want 1 11223344 00000013", d_ack, d_rdata, if_rdata);
    else passed++;
    d_req = 1'b0; m_ack = 1'b0;
    tick();
  endtask

  task automatic test_fetch_zero_wait();
    if_req = 1'b1; if_addr = 32'h100;
    tick();
    checks++;
    if ({m_req, m_addr, m_we, m_be, busy} !== {1'b1, 32'h100, 1'b0, 4'hF, 1'b1})
      $display("FAIL fetch_issue: got req=%b addr=%h we=%b be=%h busy=%b want 1 100 0 f 1", m_req, m_addr, m_we, m_be, busy);
    else passed++;
    m_ack = 1'b1; m_rdata = 32'h00500093;
    tick();
    checks++;
    if ({if_ack, d_ack, m_req, if_rdata} !== {3'b100, 32'h00500093})
      $display("FAIL fetch_ack: got if_ack=%b d_ack=%b m_req=%b if_rdata=%h want 1 0 0 00500093", if_ack, d_ack, m_req, if_rdata);
    else passed++;
    if_req = 1'b0; m_ack = 1'b0; m_rdata = 32'hFFFFFFFF;
    tick();
    checks++;
    if ({busy, if_ack, if_rdata} !== {2'b00, 32'h00500093})
      $display("FAIL fetch_cycle3: got busy=%b if_ack=%b if_rdata=%h want 0 0 00500093", busy, if_ack, if_rdata);
    else passed++;
  endtask

  task automatic test_wait_states();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_be = 4'hF; d_wdata = 32'h0;
    tick();
    checks++; if ({m_req, m_addr} !== {1'b1, 32'h300}) $display("FAIL wait_issue: got req=%b addr=%h want 1 300", m_req, m_addr); else passed++;
    for (int w = 0; w < 5; w++) begin
      tick();
      checks++;
      if ({m_req, busy, m_we, m_addr, m_be, d_ack} !== {3'b110, 32'h300, 4'hF, 1'b0})
        $display("FAIL wait_hold_%0d: got req=%b busy=%b we=%b addr=%h be=%h d_ack=%b", w, m_req, busy, m_we, m_addr, m_be, d_ack);
      else passed++;
    end
    m_ack = 1'b1; m_rdata = 32'hCAFEF00D;
    tick();
    checks++;
    if ({d_ack, m_req, d_rdata} !== {2'b10, 32'hCAFEF00D})
      $display("FAIL wait_ack: got d_ack=%b m_req=%b d_rdata=%h want 1 0 cafef00d", d_ack, m_req, d_rdata);
    else passed++;
    d_req = 1'b0; m_ack = 1'b0;
    tick();
    checks++; if ({d_ack, busy} !== 2'b00) $display("FAIL wait_ack_pulse: got d_ack=%b busy=%b want 0 0", d_ack, busy); else passed++;
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    int hi = 0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400; d_be = 4'hF; m_ack = 1'b0;
    tick();
    for (int k = 0; k < 20 && m_req; k++) begin
      hi++;
      tick();
    end
    checks++; if (hi !== TMO) $display("FAIL timeout_busy_len: got %0d want %0d", hi, TMO); else passed++;
    checks++;
    if ({d_ack, err, if_ack, d_rdata} !== {3'b110, 32'h0})
      $display("FAIL timeout_abort: got d_ack=%b err=%b if_ack=%b d_rdata=%h want 1 1 0 0", d_ack, err, if_ack, d_rdata);
    else passed++;
    d_req = 1'b0; m_ack = 1'b1; m_rdata = 32'hDEADBEEF;
    tick();
    m_ack = 1'b0;
    tick();
    checks++;
    if ({d_ack, err, m_req, busy, d_rdata} !== {4'b0000, 32'h0})
      $display("FAIL timeout_late_ack: got d_ack=%b err=%b m_req=%b busy=%b d_rdata=%h", d_ack, err, m_req, busy, d_rdata);
    else passed++;
  endtask
`endif

  task automatic test_reset_busy();
    logic [137:0] all_out;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h500; d_wdata = 32'hA5A5A5A5; d_be = 4'hF; m_ack = 1'b0;
    tick();
    checks++; if (m_req !== 1'b1) $display("FAIL rbusy_issue: got m_req=%b want 1", m_req); else passed++;
    tick(); tick();
    #3 reset = 1'b1;
    #1;
    all_out = {if_ack, d_ack, m_req, m_we, busy, err, m_be, m_addr, m_wdata, if_rdata, d_rdata};
    checks++; if (all_out !== '0) $display("FAIL rbusy_async_drop: got %h want 0", all_out); else passed++;
    d_req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if ({if_ack, d_ack, m_req} !== 3'b000) $display("FAIL rbusy_no_ack_%0d: got %b want 000", k, {if_ack, d_ack, m_req}); else passed++;
    end
    reset = 1'b0;
    if_req = 1'b1; if_addr = 32'h600;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h700;
    tick();
    checks++;
    if ({m_req, m_we, m_addr} !== {1'b1, 1'b0, 32'h700})
      $display("FAIL rbusy_data_first: got req=%b we=%b addr=%h want 1 0 700", m_req, m_we, m_addr);
    else passed++;
    tick();
    checks++; if ({if_ack, d_ack} !== 2'b00) $display("FAIL rbusy_no_ack_after: got %b want 00", {if_ack, d_ack}); else passed++;
  endtask

  task automatic new_fetch();
    if_req  = 1'b1;
    if_addr = 32'h1000 + 4 * $urandom_range(0, 15);
  endtask

  task automatic new_data();
    d_req   = 1'b1;
    d_we    = 1'($urandom % 2);
    d_addr  = 32'h1000 + 4 * $urandom_range(0, 15);
    d_wdata = $urandom;
    d_be    = 4'($urandom_range(1, 15));
  endtask

  task automatic test_random();
    logic [DW-1:0] mem [16];
    logic [DW-1:0] fl_addr, fl_wdata, exp_rd, resp;
    logic [BW-1:0] fl_be;
    bit            ptr_m, fl, fl_data, fl_we, idle_cyc, gave_ack, cur_if, cur_d;
    int            wait_left, grants;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    if_req = 1'b0; d_req = 1'b0; m_ack = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    ptr_m = 1'b1; fl = 1'b0; idle_cyc = 1'b1; wait_left = 0; grants = 0;
    fl_addr = '0; fl_wdata = '0; fl_be = '0; fl_data = 1'b0; fl_we = 1'b0; exp_rd = '0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      cur_if   = if_req;
      cur_d    = d_req;
      gave_ack = fl && m_ack;
      tick();
      if (gave_ack) begin
        checks++;
        if ({if_ack, d_ack, m_req, busy, err, (fl_data ? d_rdata : if_rdata)} !== {(fl_data ? 2'b01 : 2'b10), 3'b010, exp_rd})
          $display("FAIL rand_ack c%0d: got if_ack=%b d_ack=%b m_req=%b busy=%b err=%b if_rdata=%h d_rdata=%h want side_data=%b rdata=%h",
                   cyc, if_ack, d_ack, m_req, busy, err, if_rdata, d_rdata, fl_data, exp_rd);
        else passed++;
        fl = 1'b0; idle_cyc = 1'b0;
        if (fl_data) begin if ($urandom % 2) new_data(); else d_req = 1'b0; end
        else begin if ($urandom % 2) new_fetch(); else if_req = 1'b0; end
      end else if (fl || (idle_cyc && (cur_if || cur_d))) begin
        if (!fl) begin
          fl_data  = cur_d && (!cur_if || ptr_m);
          ptr_m    = !fl_data;
          fl_we    = fl_data ? d_we : 1'b0;
          fl_addr  = fl_data ? d_addr : if_addr;
          fl_be    = fl_data ? d_be : 4'hF;
          fl_wdata = d_wdata;
          fl = 1'b1; idle_cyc = 1'b0; grants++;
          wait_left = $urandom_range(0, 4);
        end
        checks++;
        if ({m_req, busy, if_ack, d_ack, err, m_we, m_addr, m_be, (fl_we ? m_wdata : 32'h0)} !==
            {5'b11000, fl_we, fl_addr, fl_be, (fl_we ? fl_wdata : 32'h0)})
          $display("FAIL rand_busy c%0d: got req=%b busy=%b acks=%b%b err=%b we=%b addr=%h be=%h wdata=%h want we=%b addr=%h be=%h wdata=%h",
                   cyc, m_req, busy, if_ack, d_ack, err, m_we, m_addr, m_be, m_wdata, fl_we, fl_addr, fl_be, fl_wdata);
        else passed++;
      end else begin
        checks++;
        if ({m_req, busy, if_ack, d_ack, err} !== 5'b00000)
          $display("FAIL rand_idle c%0d: got req=%b busy=%b acks=%b%b err=%b want all 0", cyc, m_req, busy, if_ack, d_ack, err);
        else passed++;
        idle_cyc = 1'b1;
      end
      // Memory side: scheduled ack while an access is in flight, stray acks otherwise.
      if (fl) begin
        if (wait_left == 0) begin
          if (fl_we) begin
            for (int b = 0; b < BW; b++)
              if (fl_be[b]) mem[fl_addr[5:2]][8*b +: 8] = fl_wdata[8*b +: 8];
            resp = $urandom;
          end else begin
            resp = mem[fl_addr[5:2]];
          end
          exp_rd = resp; m_ack = 1'b1; m_rdata = resp;
        end else begin
          wait_left--; m_ack = 1'b0; m_rdata = $urandom;
        end
      end else begin
        m_ack = ($urandom % 4 == 0); m_rdata = $urandom;
      end
      if (!if_req && ($urandom % 3 == 0)) new_fetch();
      if (!d_req && ($urandom % 3 == 0)) new_data();
    end
    checks++; if (grants < 50) $display("FAIL rand_progress: got %0d grants want >= 50", grants); else passed++;
    if_req = 1'b0; d_req = 1'b0; m_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_contention();
    test_fetch_zero_wait();
    test_wait_states();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_busy();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
